keypad_encoder: RTL and testbench

Scans a 4x4 matrix keypad (Pmod KYPD style), debounces it, and encodes the pressed key into a 4-bit hex code with a one-cycle strobe. It is the input-side counterpart of the seven-segment display path: key codes it produces feed the digit register that the display decoder renders. It runs in the system clock domain, with no derived clocks.

---
 rtl/keypad_pkg.sv | 56 +++++
 rtl/keypad_encoder_sync2.sv | 30 +++
 rtl/keypad_encoder.sv | 177 +++++++++++++++++
 tb/tb_keypad_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the 4x4 matrix keypad encoder:
//   - KEY_MAP      : hex code for each switch. The index is row*4 + col.
//   - kp_state_t   : debounce FSM states.
//   - kp_class_t   : classification of one full 16-switch scan.
//   - classify()   : counts the closed switches in a snapshot.
//   - lowest_set() : gives the index of the lowest closed switch in a snapshot.
package keypad_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } kp_class_t;

    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic kp_class_t classify(input logic [15:0] snap);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            n += int'(snap[i]);
        end
        if (n == 0) begin
            return NONE;
        end else if (n == 1) begin
            return SINGLE;
        end else begin
            return MULTI;
        end
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [3:0] lowest_set(input logic [15:0] snap);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (snap[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_encoder_sync2.sv
// sync2
//   Two-flop synchronizer for a bus of independent quasi-static lines.
//   Ports:
//     clk   - destination clock
//     reset - asynchronous, active-high; loads RST_VAL into both stages
//     d     - asynchronous input bus
//     q     - synchronized output, two clk cycles behind d
module sync2 #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder
//   Scans a 4x4 active-low matrix keypad one column at a time. It collects a
//   16-switch snapshot for each full scan, debounces the result across scans,
//   and reports the accepted key as a hex code with a one-cycle strobe.
//   Ports:
//     clk       - system clock
//     reset     - asynchronous, active-high; discards all scan/debounce progress
//     row[3:0]  - keypad rows, active-low, asynchronous (synchronized inside)
//     col[3:0]  - column drive, active-low, exactly one bit low
//     key[3:0]  - code of last accepted key; held after release
//     key_valid - one-cycle pulse when a new press is accepted
//     key_held  - high while the accepted key is considered pressed
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | no key accepted; counting consecutive scans of the same single key
//   HELD  | key accepted; counting consecutive all-open scans before release
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE);

    // ------------------------------------------------------------------
    // Row synchronizer (rows idle high, so reset to all-open)
    // ------------------------------------------------------------------
    logic [3:0] row_sync;

    sync2 #(
        .WIDTH   (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row),
        .q     (row_sync)
    );

    // ------------------------------------------------------------------
    // Column sequencer and snapshot
    // ------------------------------------------------------------------
    logic [DW-1:0]     dwell;
    logic [1:0]        c;
    logic [3:0][3:0]   snapshot;      // [row][col], flattens to bit row*4+col
    logic [3:0][3:0]   snap_next;
    logic              sample;
    logic              scan_end;

    assign sample   = (dwell == DWELL_LAST);
    assign scan_end = sample && (c == 2'd3);
    assign col      = ~(4'b0001 << c);

    // The current column is merged into the snapshot at the sample point.
    // That way the end-of-scan classification can see all 16 switches in
    // the same cycle.
    always_comb begin
        snap_next       = snapshot;
        snap_next[0][c] = ~row_sync[0];
        snap_next[1][c] = ~row_sync[1];
        snap_next[2][c] = ~row_sync[2];
        snap_next[3][c] = ~row_sync[3];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell    <= '0;
            c        <= 2'd0;
            snapshot <= '0;
        end else if (sample) begin
            dwell    <= '0;
            c        <= c + 2'd1;
            snapshot <= snap_next;
        end else begin
            dwell    <= dwell + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan classifier
    // ------------------------------------------------------------------
    kp_class_t  scan_class;
    logic [3:0] scan_code;

    assign scan_class = classify(snap_next);
    assign scan_code  = KEY_MAP[lowest_set(snap_next)];

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    kp_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_next;
    logic [3:0]    cand;
    logic          hit;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_comb begin
        cnt_next = '0;
        case (state)
            IDLE: begin
                if (scan_class == SINGLE) begin
                    cnt_next = (scan_code == cand) ? cnt_inc : CW'(1);
                end
            end
            HELD: begin
                if (scan_class == NONE) begin
                    cnt_next = cnt_inc;
                end
            end
            default: cnt_next = '0;
        endcase
    end

    assign hit = (cnt_next == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'h0;
            key       <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            key       <= scan_code;
                            key_valid <= 1'b1;
                            state     <= HELD;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_next;
                        end
                        if (scan_class == SINGLE) begin
                            cand <= scan_code;
                        end
                    end
                    HELD: begin
                        // Extra keys pressed while held only hold off the release.
                        if (hit) begin
                            state <= IDLE;
                            cnt   <= '0;
                            cand  <= 4'h0;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign key_held = (state == HELD);

endmodule

// File: tb/tb_keypad_encoder.sv
module tb_keypad_encoder;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;

    int checks = 0;
    int passed = 0;

    // Scan-level reference model
    logic [3:0] legend [16];
    int         hist [$];
    bit         m_held = 1'b0;
    logic [3:0] m_key  = 4'h0;

    keypad_encoder #(
        .SCAN_DIV (SD),
        .DEBOUNCE (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed switch pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (pressed[r*4+cc] && !col[cc]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // -1: no switch closed, -2: several closed, else: the hex code of the key
    function automatic int scan_result(input logic [15:0] p);
        if ($countones(p) == 0) return -1;
        if ($countones(p) > 1) return -2;
        for (int i = 0; i < 16; i++) if (p[i]) return int'(legend[i]);
        return -1;
    endfunction

    // A key is accepted after DB identical single-key scans while not held.
    // It is released after DB consecutive empty scans.
    task automatic model_scan(input int res, output bit strobe);
        bit same;
        strobe = 1'b0;
        hist.push_back(res);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
            same = 1'b1;
            for (int k = 0; k < DB; k++) if (hist[k] != res) same = 1'b0;
            if (same && !m_held && res >= 0) begin
                m_held = 1'b1;
                m_key  = 4'(res);
                strobe = 1'b1;
                hist.delete();
            end else if (same && m_held && res == -1) begin
                m_held = 1'b0;
                hist.delete();
            end
        end
    endtask

    // One full 16-cycle scan with the given switch set closed.
    // Call it just after the last edge of the previous scan, or just after reset is released.
    task automatic scan(input logic [15:0] p, output logic [3:0] got_key, output bit got_strobe);
        logic [3:0] ecol;
        bit         s;
        pressed    = p;
        got_key    = 4'h0;
        got_strobe = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            #1;
            ecol = ~(4'b0001 << ((j / 4) % 4));
            check("col", 32'(col), 32'(ecol));
            if (j < 16) begin
                check("key_valid_idle", 32'(key_valid), 32'd0);
                check("key_held_mid", 32'(key_held), 32'(m_held));
            end else begin
                model_scan(scan_result(p), s);
                check("key_valid_end", 32'(key_valid), 32'(s));
                check("key_held_end", 32'(key_held), 32'(m_held));
                check("key_end", 32'(key), 32'(m_key));
                got_key    = key;
                got_strobe = key_valid;
            end
        end
    endtask

    task automatic scans(input logic [15:0] p, input int n, output int strobes, output logic [3:0] last_key);
        logic [3:0] k;
        bit         s;
        strobes  = 0;
        last_key = 4'h0;
        for (int i = 0; i < n; i++) begin
            scan(p, k, s);
            if (s) begin
                strobes++;
                last_key = k;
            end
        end
    endtask

    initial begin
        string      legend_txt;
        int         st;
        logic [3:0] lk;
        logic [3:0] gk;
        bit         gs;
        logic [15:0] seen;
        int         nstrobe;

        legend_txt = "123A456B789C0FED";
        for (int i = 0; i < 16; i++) begin
            byte ch;
            ch = legend_txt[i];
            legend[i] = (ch >= "A") ? 4'(ch - "A" + 10) : 4'(ch - "0");
        end

        // Power-on reset
        #2;
        check("rst_col", 32'(col), 32'hE);
        check("rst_key", 32'(key), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single press "5" held for 5 scans
        scans(16'h0020, 5, st, lk);
        check("press5_strobes", 32'(st), 32'd1);
        check("press5_key", 32'(lk), 32'h5);

        // Asynchronous reset in the middle of a column dwell
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_col", 32'(col), 32'hE);
        check("arst_key", 32'(key), 32'h0);
        check("arst_valid", 32'(key_valid), 32'h0);
        check("arst_held", 32'(key_held), 32'h0);
        hist.delete();
        m_held = 1'b0;
        m_key  = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        scans(16'h0000, 3, st, lk);

        // Bouncing "9" for 4 scans, then stable
        scans(16'h0400, 1, st, lk);
        scans(16'h0000, 1, st, lk);
        scans(16'h0400, 1, st, lk);
        scans(16'h0000, 1, st, lk);
        check("bounce_none", 32'(key_valid | key_held), 32'd0);
        scans(16'h0400, 2, st, lk);
        check("bounce_early", 32'(st), 32'd0);
        scans(16'h0400, 1, st, lk);
        check("bounce_strobe", 32'(st), 32'd1);
        check("bounce_key", 32'(lk), 32'h9);
        scans(16'h0000, 3, st, lk);

        // Release with a re-press on "D"
        scans(16'h8000, 3, st, lk);
        check("d_key", 32'(lk), 32'hD);
        scans(16'h0000, 2, st, lk);
        check("d_held_a", 32'(key_held), 32'd1);
        scans(16'h8000, 1, st, lk);
        scans(16'h0000, 2, st, lk);
        check("d_held_b", 32'(key_held), 32'd1);
        check("d_noreacc", 32'(st), 32'd0);
        scans(16'h0000, 1, st, lk);
        check("d_released", 32'(key_held), 32'd0);
        check("d_key_kept", 32'(key), 32'hD);

        // Multi-key "1"+"2", then "1" alone
        scans(16'h0003, 6, st, lk);
        check("multi_strobes", 32'(st), 32'd0);
        check("multi_held", 32'(key_held), 32'd0);
        scans(16'h0001, 3, st, lk);
        check("multi_then1", 32'(st), 32'd1);
        check("multi_key1", 32'(lk), 32'h1);
        scans(16'h0000, 3, st, lk);

        // Every switch position in turn
        seen    = '0;
        nstrobe = 0;
        for (int i = 0; i < 16; i++) begin
            scans(16'(1) << i, 3, st, lk);
            nstrobe += st;
            check("map_code", 32'(lk), 32'(legend[i]));
            seen[lk] = 1'b1;
            scans(16'h0000, 3, st, lk);
        end
        check("map_strobes", 32'(nstrobe), 32'd16);
        check("map_distinct", 32'(seen), 32'hFFFF);

        // Random press/release/multi sequences
        for (int s = 0; s < 40; s++) begin
            int          kind;
            int          len;
            logic [15:0] p;
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                p   = 16'(1) << $urandom_range(0, 15);
                len = int'($urandom_range(1, 5));
            end else if (kind < 8) begin
                p   = '0;
                len = int'($urandom_range(1, 4));
            end else begin
                p   = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                len = int'($urandom_range(1, 3));
            end
            for (int i = 0; i < len; i++) scan(p, gk, gs);
        end
        scans(16'h0000, 3, st, lk);
        check("final_released", 32'(key_held), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
